// File: rtl/ttl_div_pkg.sv
// Shared state encodings and preset math for the TTL divider controller.
// Used by ttl_div_ctrl and, under TTL_DIV_CTRL_CHECK_EN, ttl_div_shadow.
package ttl_div_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Count-up start value so the cascade reaches all-ones after n states.
    function automatic logic [31:0] preset_of(
        input logic [31:0] n,
        input int unsigned w
    );
        logic [32:0] full;
        full = (33'd1 << w) - {1'b0, n};
        return full[31:0];
    endfunction

endpackage

// File: rtl/ttl_div_shadow.sv
// Shadow counter mirroring the TTL cascade; flags any divergence (sticky).
// Built only when TTL_DIV_CTRL_CHECK_EN is defined.
module ttl_div_shadow
    import ttl_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] preset,
    input  logic [W-1:0] ratio,
    input  logic [W-1:0] cnt_q,
    output logic         mismatch
);

    logic [W-1:0] sh_q, sh_d;
    logic         mm_q, mm_d;
    logic [W-1:0] last;

    assign last = W'(preset + ratio - W'(1));

    always_comb begin
        sh_d = sh_q;
        mm_d = mm_q;
        if (load) begin
            sh_d = preset;
        end else if (run) begin
            sh_d = (sh_q == last) ? preset : W'(sh_q + W'(1));
            if (cnt_q != sh_q) begin
                mm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
            mm_q <= 1'b0;
        end else begin
            sh_q <= sh_d;
            mm_q <= mm_d;
        end
    end

    assign mismatch = mm_q;

endmodule

// File: rtl/ttl_div_ctrl.sv
// Controller driving a cascade of 74x161 counters as a programmable divider.
// Optional cascade checker enabled by macro TTL_DIV_CTRL_CHECK_EN.
module ttl_div_ctrl
    import ttl_div_pkg::*;
#(
    parameter  int N_STAGES = 2,
    localparam int W        = 4 * N_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] div_n,
    input  logic [W-1:0] cnt_q,
    input  logic         cnt_tc,
    output logic         pe_n,
    output logic [W-1:0] p,
    output logic         cep,
    output logic         cet,
    output logic         out_pulse,
    output logic         out_sq,
    output logic         busy,
    output logic         err,
    output logic         mismatch
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic [W-1:0] preset_q, preset_d;
    logic         out_pulse_q, out_pulse_d;
    logic         out_sq_q, out_sq_d;
    logic         err_q, err_d;
    logic         stop_pend_q, stop_pend_d;
    logic         active;

    assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

    always_comb begin
        state_d     = state_q;
        ratio_d     = ratio_q;
        preset_d    = preset_q;
        stop_pend_d = stop_pend_q;
        out_pulse_d = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    if (div_n >= W'(2)) begin
                        ratio_d  = div_n;
                        preset_d = W'(preset_of(32'(div_n), W));
                        state_d  = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                stop_pend_d = stop;
                state_d     = S_RUN;
            end
            S_RUN: begin
                out_pulse_d = cnt_tc;
                if (stop || stop_pend_q) begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                out_pulse_d = cnt_tc;
                if (cnt_tc) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        out_sq_d = out_sq_q ^ out_pulse_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ratio_q     <= '0;
            preset_q    <= '0;
            out_pulse_q <= 1'b0;
            out_sq_q    <= 1'b0;
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ratio_q     <= ratio_d;
            preset_q    <= preset_d;
            out_pulse_q <= out_pulse_d;
            out_sq_q    <= out_sq_d;
            err_q       <= err_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Reload is combinational on TC so the period has no dead cycle.
    assign pe_n      = active ? ~cnt_tc : (state_q != S_LOAD);
    assign p         = (state_q == S_IDLE) ? '0 : preset_q;
    assign cep       = active;
    assign cet       = active;
    assign busy      = (state_q != S_IDLE);
    assign out_pulse = out_pulse_q;
    assign out_sq    = out_sq_q;
    assign err       = err_q;

`ifdef TTL_DIV_CTRL_CHECK_EN
    ttl_div_shadow #(
        .W(W)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == S_LOAD),
        .run      (active),
        .preset   (preset_q),
        .ratio    (ratio_q),
        .cnt_q    (cnt_q),
        .mismatch (mismatch)
    );
`else
    logic chk_unused;
    assign chk_unused = ^{ratio_q, cnt_q};
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_ttl_div_ctrl.sv
// Bench for ttl_div_ctrl driving a behavioural two-stage 74x161 cascade.
// Define TTL_DIV_CTRL_CHECK_EN to exercise the cascade checker.
module tb_ttl_div_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, stop;
    logic [W-1:0] div_n, cnt_q, p;
    logic         cnt_tc, pe_n, cep, cet;
    logic         out_pulse, out_sq, busy, err, mismatch;

    logic [3:0] q0 = 4'h0;
    logic [3:0] q1 = 4'h0;
    logic       tc0;
    logic       flip = 1'b0;

    int errors = 0;
    int checks = 0;
    int n;
    logic sq0;

`ifdef TTL_DIV_CTRL_CHECK_EN
    localparam logic MM_EXP = 1'b1;
`else
    localparam logic MM_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    assign tc0    = cet && (q0 == 4'hF);
    assign cnt_tc = tc0 && (q1 == 4'hF);
    assign cnt_q  = {q1, q0} ^ {7'b0, flip};

    always @(posedge clk) begin
        if (!pe_n) begin
            q0 <= p[3:0];
            q1 <= p[7:4];
        end else begin
            if (cep && cet) q0 <= q0 + 4'h1;
            if (cep && tc0) q1 <= q1 + 4'h1;
        end
    end

    ttl_div_ctrl #(
        .N_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .div_n     (div_n),
        .cnt_q     (cnt_q),
        .cnt_tc    (cnt_tc),
        .pe_n      (pe_n),
        .p         (p),
        .cep       (cep),
        .cet       (cet),
        .out_pulse (out_pulse),
        .out_sq    (out_sq),
        .busy      (busy),
        .err       (err),
        .mismatch  (mismatch)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pulse(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_pulse && cyc < budget);
        if (!out_pulse) check("pulse_timeout", 32'(out_pulse), 1);
    endtask

    task automatic start_run(input logic [W-1:0] d);
        div_n = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_run();
        int c;
        c = 0;
        stop = 1'b1;
        while (busy && c < 600) begin
            @(negedge clk);
            c++;
        end
        check("stop_idle", 32'(busy), 0);
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; div_n = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_pe_n", 32'(pe_n), 1);
        check("rst_p", 32'(p), 0);
        check("rst_cep", 32'(cep), 0);
        check("rst_cet", 32'(cet), 0);
        check("rst_pulse", 32'(out_pulse), 0);
        check("rst_sq", 32'(out_sq), 0);
        check("rst_err", 32'(err), 0);
        check("rst_mm", 32'(mismatch), 0);
        rst = 1'b0;
        @(negedge clk);

        start_run(8'd10);
        check("ld_pe_n", 32'(pe_n), 0);
        check("ld_p", 32'(p), 32'hF6);
        check("ld_cep", 32'(cep), 0);
        check("ld_busy", 32'(busy), 1);
        wait_pulse(50, n);
        check("d10_first", n, 11);
        check("d10_sq1", 32'(out_sq), 1);
        wait_pulse(50, n);
        check("d10_per1", n, 10);
        check("d10_sq2", 32'(out_sq), 0);
        wait_pulse(50, n);
        check("d10_per2", n, 10);
        check("d10_sq3", 32'(out_sq), 1);
        @(negedge clk);
        check("pulse_w", 32'(out_pulse), 0);
        stop_run();

        start_run(8'd2);
        check("d2_p", 32'(p), 32'hFE);
        wait_pulse(20, n);
        check("d2_first", n, 3);
        wait_pulse(20, n);
        check("d2_per1", n, 2);
        wait_pulse(20, n);
        check("d2_per2", n, 2);
        stop_run();

        start_run(8'd255);
        check("d255_p", 32'(p), 32'h01);
        wait_pulse(300, n);
        check("d255_first", n, 256);
        wait_pulse(300, n);
        check("d255_per", n, 255);
        stop_run();

        div_n = 8'd1;
        start = 1'b1;
        @(negedge clk);
        check("ill_err", 32'(err), 1);
        check("ill_busy", 32'(busy), 0);
        check("ill_pe_n", 32'(pe_n), 1);
        start = 1'b0;
        @(negedge clk);
        check("ill_err_off", 32'(err), 0);
        check("ill_busy2", 32'(busy), 0);

        start_run(8'd5);
        wait_pulse(20, n);
        check("d5_first", n, 6);
        repeat (2) @(negedge clk);
        stop = 1'b1;
        wait_pulse(20, n);
        check("stop_rem", n, 3);
        check("stop_busy", 32'(busy), 0);
        check("stop_cep", 32'(cep), 0);
        stop = 1'b0;
        @(negedge clk);
        check("stop_nopulse", 32'(out_pulse), 0);

        div_n = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b1;
        wait_pulse(20, n);
        check("ldstop_lat", n, 6);
        check("ldstop_busy", 32'(busy), 0);
        stop = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_pulse) n++;
        end
        check("ldstop_extra", n, 0);

        start_run(8'd7);
        wait_pulse(20, n);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", 32'(busy), 0);
        check("mid_pe_n", 32'(pe_n), 1);
        check("mid_p", 32'(p), 0);
        check("mid_cep", 32'(cep), 0);
        check("mid_cet", 32'(cet), 0);
        check("mid_pulse", 32'(out_pulse), 0);
        check("mid_sq", 32'(out_sq), 0);
        rst = 1'b0;
        @(negedge clk);

        start_run(8'd7);
        wait_pulse(20, n);
        check("d7_first", n, 8);
        div_n = 8'd3;
        wait_pulse(20, n);
        check("d7_per1", n, 7);
        wait_pulse(20, n);
        check("d7_per2", n, 7);
        stop_run();

        start_run(8'd10);
        wait_pulse(20, n);
        check("mm_pre", 32'(mismatch), 0);
        repeat (3) @(negedge clk);
        flip = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        @(negedge clk);
        check("mm_set", 32'(mismatch), 32'(MM_EXP));
        repeat (15) @(negedge clk);
        check("mm_hold", 32'(mismatch), 32'(MM_EXP));
        stop_run();
        check("mm_idle", 32'(mismatch), 32'(MM_EXP));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mm_clr", 32'(mismatch), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
